// File: rtl/fhd_pkg.sv
// Shared constants for the SPI DAC responder: frame layout, register map, FSM encoding.
package fhd_pkg;

   localparam int unsigned FRAME_BITS_DEF = 24;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned NUM_CH         = 4;

   // Frame field positions (MSB-first frame)
   localparam int unsigned RW_BIT   = 23;
   localparam int unsigned ADDR_MSB = 19;
   localparam int unsigned ADDR_LSB = 16;
   localparam int unsigned DATA_MSB = 15;

   // Register map
   localparam logic [3:0] ADDR_ID     = 4'h1;
   localparam logic [3:0] ADDR_SYNC   = 4'h2;
   localparam logic [3:0] ADDR_TRIG   = 4'h5;
   localparam logic [1:0] ADDR_BUF_HI = 2'b10;  // 0x08-0x0B: upper address bits
   localparam int unsigned TRIG_LDAC_BIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/fhd_sync2.sv
// Two-flop synchroniser with a parameterised reset value.
// Ports: clk, rst (async active-high), d_i (async input), q_o (synchronised output).
module fhd_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/fhd_spi_responder.sv
// SPI-controlled 4-channel DAC register responder with buffered (SYNC/LDAC) updates
// and one-shot register readback.
// Ports: clk/rst system clock and async active-high reset; fhd_clk_i/fhd_csn_i/fhd_sdi_i
// SPI slave inputs; ldacn_i hardware load-DAC; fhd_sdo_o readback data; vout0-3_o active
// DAC codes; wr_strobe_o pulse per committed write; frame_err_o pulse per bad-length frame.
module fhd_spi_responder
   import fhd_pkg::*;
#(
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
   parameter logic [15:0] DEVICE_ID  = 16'h0215
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fhd_clk_i,
   input  logic        fhd_csn_i,
   input  logic        fhd_sdi_i,
   input  logic        ldacn_i,
   output logic        fhd_sdo_o,
   output logic [15:0] vout0_o,
   output logic [15:0] vout1_o,
   output logic [15:0] vout2_o,
   output logic [15:0] vout3_o,
   output logic        wr_strobe_o,
   output logic        frame_err_o
);

   localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);

   logic sclk_s, csn_s, sdi_s, ldacn_s;

   fhd_sync2 #(.RST_VAL(1'b0)) u_sync_sclk  (.clk(clk), .rst(rst), .d_i(fhd_clk_i), .q_o(sclk_s));
   fhd_sync2 #(.RST_VAL(1'b1)) u_sync_csn   (.clk(clk), .rst(rst), .d_i(fhd_csn_i), .q_o(csn_s));
   fhd_sync2 #(.RST_VAL(1'b0)) u_sync_sdi   (.clk(clk), .rst(rst), .d_i(fhd_sdi_i), .q_o(sdi_s));
   fhd_sync2 #(.RST_VAL(1'b1)) u_sync_ldacn (.clk(clk), .rst(rst), .d_i(ldacn_i),   .q_o(ldacn_s));

   state_e                state_q, state_d;
   logic                  sclk_prev_q, csn_prev_q, ldacn_prev_q;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] rx_q, rx_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d;
   logic [FRAME_BITS-1:0] rd_q, rd_d;
   logic                  sdo_q, sdo_d;
   logic [NUM_CH-1:0]     sync_q, sync_d;
   logic [DATA_W-1:0]     buf_q  [NUM_CH];
   logic [DATA_W-1:0]     buf_d  [NUM_CH];
   logic [DATA_W-1:0]     vout_q [NUM_CH];
   logic [DATA_W-1:0]     vout_d [NUM_CH];
   logic                  wr_q, wr_d;
   logic                  err_q, err_d;

   // Edge detection on synchronised inputs
   logic csn_fall, csn_rise, sclk_fall, sclk_rise, ldac_fall;
   assign csn_fall  =  csn_prev_q   & ~csn_s;
   assign csn_rise  = ~csn_prev_q   &  csn_s;
   assign sclk_fall =  sclk_prev_q  & ~sclk_s;
   assign sclk_rise = ~sclk_prev_q  &  sclk_s;
   assign ldac_fall =  ldacn_prev_q & ~ldacn_s;

   // Frame field decode
   logic [3:0]        addr;
   logic [DATA_W-1:0] data;
   logic              commit_wr, commit_rd, ldac_ev;
   assign addr      = rx_q[ADDR_MSB:ADDR_LSB];
   assign data      = rx_q[DATA_MSB:0];
   assign commit_wr = (state_q == ST_COMMIT) & ~rx_q[RW_BIT];
   assign commit_rd = (state_q == ST_COMMIT) &  rx_q[RW_BIT];
   assign ldac_ev   = ldac_fall | (commit_wr & (addr == ADDR_TRIG) & data[TRIG_LDAC_BIT]);

   // Readback mux
   logic [DATA_W-1:0] rd_val;
   always_comb begin
      rd_val = '0;
      if (addr == ADDR_ID) begin
         rd_val = DEVICE_ID;
      end else if (addr == ADDR_SYNC) begin
         rd_val = DATA_W'(sync_q);
      end else if (addr[3:2] == ADDR_BUF_HI) begin
         rd_val = buf_q[addr[1:0]];
      end
   end

   // Next-state and datapath
   logic buf_hit;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      rd_d    = rd_q;
      sdo_d   = sdo_q;
      sync_d  = sync_q;
      buf_d   = buf_q;
      vout_d  = vout_q;
      wr_d    = 1'b0;
      err_d   = 1'b0;
      buf_hit = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sdo_d = 1'b0;
            if (csn_fall) begin
               // Move the pending read word into the shifter; it is consumed by this frame
               state_d = ST_SHIFT;
               cnt_d   = '0;
               rx_d    = '0;
               tx_d    = rd_q;
               sdo_d   = rd_q[FRAME_BITS-1];
               rd_d    = '0;
            end
         end
         ST_SHIFT: begin
            if (csn_rise) begin
               sdo_d = 1'b0;
               if (cnt_q == CNT_W'(FRAME_BITS)) begin
                  state_d = ST_COMMIT;
                  wr_d    = ~rx_q[RW_BIT];
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end else begin
               if (sclk_fall) begin
                  rx_d = {rx_q[FRAME_BITS-2:0], sdi_s};
                  if (cnt_q != CNT_W'(FRAME_BITS + 1)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               // MSB is already on the line from csn fall, so the first rising edge holds
               if (sclk_rise && (cnt_q != '0)) begin
                  tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
                  sdo_d = tx_q[FRAME_BITS-2];
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (commit_rd) begin
               rd_d = FRAME_BITS'({8'h00, rd_val});
            end
            if (commit_wr && (addr == ADDR_SYNC)) begin
               sync_d = data[NUM_CH-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Buffer writes and LDAC transfers; a coincident write wins with its new value
      for (int ch = 0; ch < NUM_CH; ch++) begin
         buf_hit = commit_wr && (addr[3:2] == ADDR_BUF_HI) && (addr[1:0] == 2'(ch));
         if (buf_hit) begin
            buf_d[ch] = data;
            if (!sync_q[ch] || ldac_ev) begin
               vout_d[ch] = data;
            end
         end else if (ldac_ev && sync_q[ch]) begin
            vout_d[ch] = buf_q[ch];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sclk_prev_q  <= 1'b0;
         csn_prev_q   <= 1'b1;
         ldacn_prev_q <= 1'b1;
         cnt_q        <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         rd_q         <= '0;
         sdo_q        <= 1'b0;
         sync_q       <= '0;
         wr_q         <= 1'b0;
         err_q        <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            buf_q[i]  <= '0;
            vout_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         sclk_prev_q  <= sclk_s;
         csn_prev_q   <= csn_s;
         ldacn_prev_q <= ldacn_s;
         cnt_q        <= cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         rd_q         <= rd_d;
         sdo_q        <= sdo_d;
         sync_q       <= sync_d;
         wr_q         <= wr_d;
         err_q        <= err_d;
         buf_q        <= buf_d;
         vout_q       <= vout_d;
      end
   end

   assign fhd_sdo_o   = sdo_q;
   assign vout0_o     = vout_q[0];
   assign vout1_o     = vout_q[1];
   assign vout2_o     = vout_q[2];
   assign vout3_o     = vout_q[3];
   assign wr_strobe_o = wr_q;
   assign frame_err_o = err_q;

endmodule

// File: tb/tb_fhd_spi_responder.sv
// Directed testbench for fhd_spi_responder with a reference model and scoreboard queues.
module tb_fhd_spi_responder;

   logic        clk, rst;
   logic        fhd_clk_i, fhd_csn_i, fhd_sdi_i, ldacn_i;
   logic        fhd_sdo_o;
   logic [15:0] vout0_o, vout1_o, vout2_o, vout3_o;
   logic        wr_strobe_o, frame_err_o;

   fhd_spi_responder dut (
      .clk(clk), .rst(rst),
      .fhd_clk_i(fhd_clk_i), .fhd_csn_i(fhd_csn_i), .fhd_sdi_i(fhd_sdi_i), .ldacn_i(ldacn_i),
      .fhd_sdo_o(fhd_sdo_o),
      .vout0_o(vout0_o), .vout1_o(vout1_o), .vout2_o(vout2_o), .vout3_o(vout3_o),
      .wr_strobe_o(wr_strobe_o), .frame_err_o(frame_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int err_cnt = 0;

   always @(posedge clk) begin
      if (wr_strobe_o) wr_cnt <= wr_cnt + 1;
      if (frame_err_o) err_cnt <= err_cnt + 1;
   end

   // Reference model
   logic [3:0]  m_sync;
   logic [15:0] m_buf  [4];
   logic [15:0] m_vout [4];
   logic [23:0] m_rd;

   logic [63:0] exp_vout_q [$];
   logic [23:0] exp_rd_q   [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_sync = '0;
      m_rd   = '0;
      for (int i = 0; i < 4; i++) begin
         m_buf[i]  = '0;
         m_vout[i] = '0;
      end
   endtask

   task automatic model_ldac();
      for (int i = 0; i < 4; i++) if (m_sync[i]) m_vout[i] = m_buf[i];
   endtask

   task automatic model_write(input logic [3:0] a, input logic [15:0] d, input bit ldac);
      int  ch;
      bit  ev;
      ev = ldac || (a == 4'h5 && d[4]);
      ch = -1;
      if (a >= 4'h8 && a <= 4'hB) begin
         ch = int'(a) - 8;
         m_buf[ch] = d;
      end
      if (ev) model_ldac();
      if (ch >= 0 && !m_sync[ch]) m_vout[ch] = d;
      if (a == 4'h2) m_sync = d[3:0];
   endtask

   function automatic logic [15:0] model_read(input logic [3:0] a);
      if (a == 4'h1) return 16'h0215;
      if (a == 4'h2) return {12'h000, m_sync};
      if (a >= 4'h8 && a <= 4'hB) return m_buf[int'(a) - 8];
      return 16'h0000;
   endfunction

   task automatic push_vout();
      exp_vout_q.push_back({m_vout[3], m_vout[2], m_vout[1], m_vout[0]});
   endtask

   task automatic check_vouts(input string tag);
      logic [63:0] e;
      if (exp_vout_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard underflow observed=empty expected=entry", tag);
      end else begin
         e = exp_vout_q.pop_front();
         chk({tag, "_vout0"}, 32'(vout0_o), 32'(e[15:0]));
         chk({tag, "_vout1"}, 32'(vout1_o), 32'(e[31:16]));
         chk({tag, "_vout2"}, 32'(vout2_o), 32'(e[47:32]));
         chk({tag, "_vout3"}, 32'(vout3_o), 32'(e[63:48]));
      end
   endtask

   // Drive csn low and clock out nbits MSB first; SDI set on rising, SDO captured before falling.
   task automatic shift_bits(input logic [23:0] word, input int nbits, output logic [23:0] miso);
      miso = '0;
      fhd_csn_i = 1'b0;
      tick(8);
      for (int i = 0; i < nbits; i++) begin
         fhd_clk_i = 1'b1;
         fhd_sdi_i = word[23-i];
         tick(8);
         miso[23-i] = fhd_sdo_o;
         fhd_clk_i = 1'b0;
         tick(8);
      end
   endtask

   task automatic do_frame(input string tag, input logic [23:0] word, input int nbits,
                           input bit ldac_at_commit);
      logic [23:0] miso;
      bit          full, is_wr;
      int          wr0, err0;
      full  = (nbits == 24);
      is_wr = full && !word[23];
      wr0   = wr_cnt;
      err0  = err_cnt;
      exp_rd_q.push_back(m_rd);
      m_rd = '0;
      if (is_wr) model_write(word[19:16], word[15:0], ldac_at_commit);
      if (full && word[23]) m_rd = {8'h00, model_read(word[19:16])};
      push_vout();

      shift_bits(word, nbits, miso);
      fhd_csn_i = 1'b1;
      if (ldac_at_commit) begin
         tick(1);
         ldacn_i = 1'b0;
         tick(2);
      end else begin
         tick(3);
      end
      chk({tag, "_wr_strobe"}, 32'(wr_strobe_o), 32'(is_wr));
      chk({tag, "_frame_err"}, 32'(frame_err_o), 32'(!full));
      tick(1);
      check_vouts(tag);
      if (full) chk({tag, "_miso"}, 32'(miso), 32'(exp_rd_q.pop_front()));
      else void'(exp_rd_q.pop_front());
      tick(6);
      ldacn_i = 1'b1;
      chk({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(is_wr));
      chk({tag, "_err_count"}, 32'(err_cnt - err0), 32'(!full));
      tick(4);
   endtask

   logic [23:0] dummy;
   int          err_before;

   initial begin
      rst = 1'b1;
      fhd_clk_i = 1'b0;
      fhd_csn_i = 1'b1;
      fhd_sdi_i = 1'b0;
      ldacn_i   = 1'b1;
      model_reset();
      tick(5);
      chk("rst_sdo", 32'(fhd_sdo_o), 32'd0);
      chk("rst_wr", 32'(wr_strobe_o), 32'd0);
      chk("rst_err", 32'(frame_err_o), 32'd0);
      push_vout();
      check_vouts("rst");
      rst = 1'b0;
      tick(4);

      // Immediate write
      do_frame("imm_wr", 24'h08_1234, 24, 1'b0);

      // Synchronous load via ldacn pulse
      do_frame("sync_set", 24'h02_0003, 24, 1'b0);
      do_frame("buf_wr1", 24'h09_AAAA, 24, 1'b0);
      ldacn_i = 1'b0;
      model_ldac();
      tick(10);
      ldacn_i = 1'b1;
      tick(5);
      push_vout();
      check_vouts("ldac_pulse");

      // Readback chain, including one-shot clear of the read word
      do_frame("rd_id", 24'h81_0000, 24, 1'b0);
      do_frame("rd_sync", 24'h82_0000, 24, 1'b0);
      do_frame("rd_buf1", 24'h89_0000, 24, 1'b0);
      do_frame("wr_ign", 24'h0F_0000, 24, 1'b0);
      do_frame("rd_clr", 24'h0F_0000, 24, 1'b0);

      // Short frame
      do_frame("short", 24'h08_5555, 20, 1'b0);

      // LDAC edge coincident with buffer write
      do_frame("sync4", 24'h02_0004, 24, 1'b0);
      do_frame("coinc", 24'h0A_BEEF, 24, 1'b1);

      // Soft LDAC via TRIGGER; bits 22:20 set on the buffer write are ignored
      do_frame("sync2", 24'h02_0002, 24, 1'b0);
      do_frame("buf_wr2", 24'h79_1111, 24, 1'b0);
      do_frame("trig", 24'h05_0010, 24, 1'b0);

      // Reset mid-frame
      err_before = err_cnt;
      shift_bits(24'h0B_1234, 12, dummy);
      rst = 1'b1;
      model_reset();
      tick(2);
      fhd_csn_i = 1'b1;
      fhd_clk_i = 1'b0;
      tick(2);
      chk("mid_rst_sdo", 32'(fhd_sdo_o), 32'd0);
      chk("mid_rst_wr", 32'(wr_strobe_o), 32'd0);
      chk("mid_rst_err", 32'(frame_err_o), 32'd0);
      push_vout();
      check_vouts("mid_rst");
      rst = 1'b0;
      tick(8);
      chk("mid_rst_no_err_pulse", 32'(err_cnt - err_before), 32'd0);
      do_frame("post_rst", 24'h0B_00FF, 24, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
